// File: rtl/vec_exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_exec_seq_pkg
// Purpose  : Shared types and defaults for the vector execution sequencer:
//            element op-code enum, FSM state typedef, default element width.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package vec_exec_seq_pkg;

   localparam int DEF_ELEMENT = 16;
   localparam int OP_W        = 3;
   localparam int TAG_W       = 4;

   // Element operation codes. Both 3'b011 and 3'b100 are logical right shifts.
   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_SRL = 3'b011,
      OP_SRA = 3'b100,
      OP_SLL = 3'b101,
      OP_AND = 3'b110,
      OP_NOP = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : vec_exec_seq_pkg
`default_nettype wire

// File: rtl/vec_exec_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_exec_seq_if
// Purpose  : Operation-in / result-out handshake bundle of vec_exec_seq.
// Ports    : in_valid/in_ready/in_op/in_vec_a/in_vec_b/in_tag  (request)
//            out_valid/out_ready/out_vec/out_tag               (result)
//            modport slave  - seen from the sequencer
//            modport master - seen from the requester / consumer
// Revision : 1.0 - initial release
// ============================================================================
interface vec_exec_seq_if
   import vec_exec_seq_pkg::*;
#(
   parameter int ELEMENT = DEF_ELEMENT,
   parameter int VLEN    = 8
);

   logic                      in_valid;
   logic                      in_ready;
   logic [OP_W-1:0]           in_op;
   logic [VLEN*ELEMENT-1:0]   in_vec_a;
   logic [VLEN*ELEMENT-1:0]   in_vec_b;
   logic [TAG_W-1:0]          in_tag;
   logic                      out_valid;
   logic                      out_ready;
   logic [VLEN*ELEMENT-1:0]   out_vec;
   logic [TAG_W-1:0]          out_tag;

   modport slave (
      input  in_valid, in_op, in_vec_a, in_vec_b, in_tag, out_ready,
      output in_ready, out_valid, out_vec, out_tag
   );

   modport master (
      output in_valid, in_op, in_vec_a, in_vec_b, in_tag, out_ready,
      input  in_ready, out_valid, out_vec, out_tag
   );

endinterface : vec_exec_seq_if
`default_nettype wire

// File: rtl/vec_exec_seq_alu_lane.sv
`default_nettype none
// ============================================================================
// Module   : alu_lane
// Purpose  : Purely combinational single-element ALU. All arithmetic is
//            unsigned and truncated to ELEMENT bits.
// Ports    : op (in)  - element operation
//            a, b (in) - element operands (b is the shift amount for shifts)
//            y (out)  - element result
// Revision : 1.0 - initial release
// ============================================================================
module alu_lane
   import vec_exec_seq_pkg::*;
#(
   parameter int ELEMENT = DEF_ELEMENT
) (
   input  op_t                op,
   input  logic [ELEMENT-1:0] a,
   input  logic [ELEMENT-1:0] b,
   output logic [ELEMENT-1:0] y
);

   // Any shift distance of a full element or more clears the result.
   logic w_shift_oob;
   assign w_shift_oob = (b >= ELEMENT'(ELEMENT));

   always_comb begin
      y = '0;
      case (op)
         OP_ADD: y = a + b;
         OP_SUB: y = a - b;
         OP_MUL: y = a * b;
         OP_SRL,
         OP_SRA: y = w_shift_oob ? '0 : (a >> b);
         OP_SLL: y = w_shift_oob ? '0 : (a << b);
         OP_AND: y = a & b;
         OP_NOP: y = '0;
         default: y = '0;
      endcase
   end

endmodule : alu_lane
`default_nettype wire

// File: rtl/vec_exec_seq.sv
`default_nettype none
// ============================================================================
// Module   : vec_exec_seq
// Purpose  : Multi-cycle vector execution sequencer. Accepts one vector
//            operation, computes LANES elements per cycle through alu_lane
//            instances, then presents the result until it is taken.
// Ports    : clk  (in)  - clock, rising edge
//            rst  (in)  - asynchronous active-high reset
//            bus  (vec_exec_seq_if.slave) - request and result handshakes
//            busy (out) - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module vec_exec_seq
   import vec_exec_seq_pkg::*;
#(
   parameter int ELEMENT = DEF_ELEMENT,
   parameter int VLEN    = 8,
   parameter int LANES   = 2      // VLEN must be a multiple of LANES
) (
   input  logic                 clk,
   input  logic                 rst,
   vec_exec_seq_if.slave        bus,
   output logic                 busy
);

   localparam int GROUPS = VLEN / LANES;
   localparam int CNT_W  = $clog2(GROUPS + 1);
   localparam int VEC_W  = VLEN * ELEMENT;
   // The counter runs one past the last group: the extra EXEC cycle spent at
   // this value is what moves into DONE, giving GROUPS+1 cycles of latency.
   localparam logic [CNT_W-1:0] END_CNT = CNT_W'(GROUPS);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_group;
   logic [VEC_W-1:0]   r_vec_a;
   logic [VEC_W-1:0]   r_vec_b;
   logic [VEC_W-1:0]   r_result;
   op_t                r_op;
   logic [TAG_W-1:0]   r_tag;

   logic               w_accept;
   logic               w_exec;
   logic [CNT_W-1:0]   w_grp;
   logic [ELEMENT-1:0] w_lane_a [LANES];
   logic [ELEMENT-1:0] w_lane_b [LANES];
   logic [ELEMENT-1:0] w_lane_y [LANES];

   // ------------------------------------------------------------------
   // Handshake outputs
   // ------------------------------------------------------------------
   assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_vec   = r_result;
   assign bus.out_tag   = r_tag;
   assign busy          = (r_state != ST_IDLE);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and datapath strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_exec   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_accept = 1'b1;
               w_next   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (r_group == END_CNT) begin
               w_next = ST_DONE;
            end else begin
               w_exec = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Keep lane selects in range during the terminal EXEC cycle.
   assign w_grp = (r_group < END_CNT) ? r_group : '0;

   // ------------------------------------------------------------------
   // Lane datapath: element index = group * LANES + lane
   // ------------------------------------------------------------------
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign w_lane_a[l] = r_vec_a[(32'(w_grp) * LANES + l) * ELEMENT +: ELEMENT];
         assign w_lane_b[l] = r_vec_b[(32'(w_grp) * LANES + l) * ELEMENT +: ELEMENT];

         alu_lane #(
            .ELEMENT (ELEMENT)
         ) u_alu_lane (
            .op (r_op),
            .a  (w_lane_a[l]),
            .b  (w_lane_b[l]),
            .y  (w_lane_y[l])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Operand latch, group counter and result register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec_a  <= '0;
         r_vec_b  <= '0;
         r_op     <= OP_NOP;
         r_tag    <= '0;
         r_group  <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_vec_a  <= bus.in_vec_a;
         r_vec_b  <= bus.in_vec_b;
         r_op     <= op_t'(bus.in_op);
         r_tag    <= bus.in_tag;
         r_group  <= '0;
      end else if (w_exec) begin
         for (int l = 0; l < LANES; l++) begin
            r_result[(32'(w_grp) * LANES + l) * ELEMENT +: ELEMENT] <= w_lane_y[l];
         end
         r_group <= r_group + CNT_W'(1);
      end
   end

endmodule : vec_exec_seq
`default_nettype wire

// File: tb/tb_vec_exec_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_exec_seq
// Purpose  : Self-checking bench for vec_exec_seq. Directed operations push
//            hand-computed results into a scoreboard; a monitor pops and
//            compares on every result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_exec_seq;

   localparam int EW = 16;
   localparam int VL = 8;
   localparam int LN = 2;
   localparam int VW = VL * EW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;

   vec_exec_seq_if #(.ELEMENT(EW), .VLEN(VL)) bus ();

   vec_exec_seq #(
      .ELEMENT (EW),
      .VLEN    (VL),
      .LANES   (LN)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [VW-1:0] vec;
      logic [3:0]    tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   time  hs_time  = 0;
   time  acc_time = 0;

   localparam logic [VW-1:0] ONES = {8{16'h0001}};
   localparam logic [VW-1:0] IDX  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result monitor / scoreboard consumer
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         hs_time = $time;
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: out_valid with nothing pending, tag %h vec %h",
                     bus.out_tag, bus.out_vec);
         end else begin
            e = sb.pop_front();
            check("result_vec", bus.out_vec, e.vec);
            check("result_tag", VW'(bus.out_tag), VW'(e.tag));
         end
      end
   end

   // Offer one operation; returns 1 ns after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [3:0] tag, input logic [VW-1:0] exp_vec,
                        input bit expect_out, input bit hold_valid);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_vec_a = a;
      bus.in_vec_b = b;
      bus.in_tag   = tag;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc_time = $time;
            if (expect_out) sb.push_back('{vec: exp_vec, tag: tag});
            ok = 1'b1;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL accept_timeout: tag %h not accepted in 100 cycles", tag);
      end
      tick();
      if (!hold_valid) bus.in_valid = 1'b0;
      // Scramble inputs so a missing operand latch shows up as a wrong result
      bus.in_vec_a = {4{32'hDEAD_BEEF}};
      bus.in_vec_b = {4{32'h5A5A_A5A5}};
      bus.in_op    = 3'b111;
      bus.in_tag   = 4'hF;
   endtask

   task automatic drain();
      int i = 0;
      while ((sb.size() != 0 || busy) && i < 60) begin
         tick();
         i++;
      end
      if (sb.size() != 0 || busy) begin
         n_checks++;
         $display("FAIL drain_timeout: pending %0d busy %b", sb.size(), busy);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [3:0] tag, input logic [VW-1:0] exp_vec);
      issue(op, a, b, tag, exp_vec, 1'b1, 1'b0);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  seen;
      time hs_old;

      bus.in_valid  = 1'b0;
      bus.in_op     = 3'b000;
      bus.in_vec_a  = '0;
      bus.in_vec_b  = '0;
      bus.in_tag    = 4'h0;
      bus.out_ready = 1'b1;

      // ---------------- reset state ----------------
      #2 rst = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", VW'(bus.out_valid), '0);
      check("rst_busy",      VW'(busy),          '0);
      check("rst_out_vec",   bus.out_vec,        '0);
      check("rst_out_tag",   VW'(bus.out_tag),   '0);
      rst = 1'b0;
      #1;
      check("rst_in_ready",  VW'(bus.in_ready),  VW'(1));

      // ---------------- ADD with latency ----------------
      issue(3'b000, ONES, IDX, 4'h3, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 1'b0);
      check("exec_busy",     VW'(busy),          VW'(1));
      check("exec_in_ready", VW'(bus.in_ready),  '0);
      lat = 0;
      while (lat < 20) begin
         tick();
         lat++;
         if (bus.out_valid) break;
      end
      check("add_latency", VW'(lat), VW'(5));
      tick();
      check("add_one_cycle_valid", VW'(bus.out_valid), '0);
      drain();

      // ---------------- arithmetic / logic vectors ----------------
      run_op(3'b001, '0, ONES, 4'h4, {8{16'hFFFF}});
      run_op(3'b010, {8{16'h0100}}, {8{16'h0100}}, 4'h5, '0);
      run_op(3'b010, {8{16'h0003}}, IDX, 4'h6, 128'h0015_0012_000F_000C_0009_0006_0003_0000);
      run_op(3'b101, {8{16'h8001}}, ONES, 4'h7, {8{16'h0002}});
      run_op(3'b101, {8{16'h8001}}, 128'h0010_000F_0004_0000_0010_000F_0004_0000, 4'h8,
             128'h0000_8000_0010_8001_0000_8000_0010_8001);
      run_op(3'b011, {8{16'h8001}}, 128'h0004_FFFF_0010_000F_0001_0000_0010_000F, 4'h9,
             128'h0800_0000_0000_0001_4000_8001_0000_0001);
      run_op(3'b100, {8{16'h8001}}, 128'h0004_FFFF_0010_000F_0001_0000_0010_000F, 4'hA,
             128'h0800_0000_0000_0001_4000_8001_0000_0001);
      run_op(3'b110, 128'hFFFF_0F0F_1234_AAAA_0000_FFFF_00FF_F0F0,
             128'h1234_FFFF_FFFF_5555_FFFF_0000_0FF0_FF00, 4'hB,
             128'h1234_0F0F_1234_0000_0000_0000_00F0_F000);
      run_op(3'b111, 128'hFFFF_0F0F_1234_AAAA_0000_FFFF_00FF_F0F0, IDX, 4'hC, '0);
      run_op(3'b000, {8{16'hFFFF}}, IDX, 4'hD, 128'h0006_0005_0004_0003_0002_0001_0000_FFFF);

      // ---------------- backpressure ----------------
      bus.out_ready = 1'b0;
      issue(3'b000, ONES, ONES, 4'h1, {8{16'h0002}}, 1'b1, 1'b0);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      for (int i = 0; i < 10; i++) begin
         check("bp_out_vec",   bus.out_vec,         {8{16'h0002}});
         check("bp_in_ready",  VW'(bus.in_ready),   '0);
         check("bp_out_valid", VW'(bus.out_valid),  VW'(1));
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_release_in_ready",  VW'(bus.in_ready),  VW'(1));
      check("bp_release_out_valid", VW'(bus.out_valid), '0);
      drain();

      // ---------------- reset mid-EXEC ----------------
      issue(3'b000, ONES, ONES, 4'h2, '0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid", VW'(bus.out_valid), '0);
      check("rst_mid_busy",      VW'(busy),          '0);
      check("rst_mid_out_vec",   bus.out_vec,        '0);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      check("rst_mid_no_result", VW'(seen), '0);
      run_op(3'b001, IDX, ONES, 4'hE, 128'h0006_0005_0004_0003_0002_0001_0000_FFFF);

      // ---------------- back-to-back with in_valid held ----------------
      hs_old = hs_time;
      issue(3'b000, IDX, IDX, 4'h5, 128'h000E_000C_000A_0008_0006_0004_0002_0000, 1'b1, 1'b1);
      issue(3'b110, IDX, {8{16'h0006}}, 4'h6, 128'h0006_0006_0004_0004_0002_0002_0000_0000,
            1'b1, 1'b0);
      check("b2b_accept_after_handshake", VW'(hs_time > hs_old && acc_time > hs_time), VW'(1));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_vec_exec_seq
`default_nettype wire

// File: doc/vec_exec_seq.md
VEC_EXEC_SEQ -- requirements
Module: vec_exec_seq

Interface
REQ-001 Parameter ELEMENT, default 16, SHALL set the element width in bits.
REQ-002 Parameter VLEN, default 8, SHALL set the number of elements per vector.
REQ-003 Parameter LANES, default 2, SHALL set the number of elements processed per cycle; VLEN SHALL be a multiple of LANES.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 in_valid  in  1  SHALL mean a vector operation is offered.
REQ-007 in_ready  out  1  SHALL mean the block accepts the offered operation this cycle.
REQ-008 in_op  in  3  SHALL be the element operation code.
REQ-009 in_vec_a, in_vec_b  in  VLEN*ELEMENT  SHALL be the operand vectors; element i SHALL occupy bits [i*ELEMENT +: ELEMENT].
REQ-010 in_tag  in  4  SHALL be the destination register tag, passed through unchanged.
REQ-011 out_valid  out  1  SHALL mean a completed result is presented.
REQ-012 out_ready  in  1  SHALL mean downstream accepts the result this cycle.
REQ-013 out_vec  out  VLEN*ELEMENT  SHALL be the result vector, in the same element packing as the operands.
REQ-014 out_tag  out  4  SHALL be the tag of the presented result.
REQ-015 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, and DONE.
REQ-017 in_ready SHALL equal 1 only in IDLE.
REQ-018 Accept occurs when in_valid and in_ready are both high: operands, op, and tag SHALL be latched; group counter SHALL be cleared to 0; FSM SHALL go to EXEC.
REQ-019 In EXEC, each cycle SHALL compute elements g*LANES through g*LANES+LANES-1 and write them into the result register, then increment g.
REQ-020 After the group with g = VLEN/LANES-1, FSM SHALL go to DONE, so out_valid rises exactly VLEN/LANES+1 cycles after the accept edge (default 5).
REQ-021 In DONE, out_valid SHALL be 1, and out_vec/out_tag SHALL be held stable until out_valid and out_ready are both high; then FSM SHALL go to IDLE.
REQ-022 No new operation SHALL be accepted in the same cycle as the out handshake (in_ready = 0 in DONE).
REQ-023 Latched operands SHALL be unaffected by input changes after accept.
REQ-024 Op codes, per element, unsigned, result truncated to ELEMENT bits:
- 000: a+b, wrapping mod 2^ELEMENT
- 001: a-b, wrapping
- 010: low ELEMENT bits of a*b
- 011: a logical-shift-right by b
- 100: a logical-shift-right by b
- 101: a shift-left by b
- 110: a AND b
- 111: result 0
REQ-025 A shift amount b >= ELEMENT SHALL yield 0.
REQ-026 Element results SHALL be independent; no carry crosses element boundaries.

Reset
REQ-027 rst SHALL immediately force the FSM to IDLE and set: out_valid=0, busy=0, out_vec=0, out_tag=0, group counter=0. in_ready SHALL be 1 once rst deasserts.
REQ-028 rst asserted during EXEC or DONE SHALL discard the in-flight operation; no out_valid SHALL be produced for it.

Structure
REQ-029 A shared package SHALL hold the op-code enum (ADD, SUB, MUL, SRL, SRA, SLL, AND, NOP), the FSM state typedef, and the ELEMENT default.
REQ-030 Per-element computation SHALL be a combinational sub-module, alu_lane, instantiated LANES times; all sequencing SHALL remain in vec_exec_seq.

Verification
REQ-031 ADD: a = all 0x0001, b = elements 0..7, out_ready=1 -> out_vec elements 1..8, tag echoed, out_valid at accept+5 for one cycle.
REQ-032 Wrap: SUB with a=0x0000, b=0x0001 in all elements -> all elements 0xFFFF; MUL 0x0100*0x0100 -> 0x0000.
REQ-033 Shifts: a=0x8001 with SLL b=1 -> 0x0002; SRL b=15 -> 0x0001; SRL b=16 -> 0x0000.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_vec stable, in_ready=0; raise out_ready -> one handshake, in_ready=1 next cycle.
REQ-035 Reset mid-EXEC: assert rst at accept+2 -> out_valid=0, busy=0 immediately; no result emitted; next op completes correctly.
REQ-036 Back-to-back: in_valid held high with two ops -> second accepted only after the first out handshake; both results correct, in order.
